ocram_port_arbiter: RTL
=======================

OCRAM_PORT_ARBITER -- requirements
Module: ocram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width of RAM and both ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk  input  1  meaning single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have, for p in {m0, m1}: p_address  input  ADDR_W  meaning word address.
REQ-006 SHALL have p_byteenable  input  DATA_W/8  meaning byte lanes for write.
REQ-007 SHALL have p_read and p_write  input  1 each  meaning transfer request; both high is illegal.
REQ-008 SHALL have p_writedata  input  DATA_W  meaning write data.
REQ-009 SHALL have p_lock  input  1  meaning keep grant after this transfer.
REQ-010 SHALL have p_waitrequest  output  1  meaning request not accepted this cycle.
REQ-011 SHALL have p_readdata  output  DATA_W, and p_readdatavalid  output  1.
REQ-012 SHALL have RAM side outputs ram_address ADDR_W, ram_byteenable DATA_W/8, ram_chipselect 1, ram_write 1, ram_writedata DATA_W, ram_clken 1; input ram_readdata DATA_W.

Function
REQ-013 SHALL accept at most one transfer per cycle; accepted = request high and p_waitrequest low in the same cycle.
REQ-014 SHALL drive ram_* combinationally from the granted port: ram_chipselect = accepted; ram_write = accepted write; ram_clken = 1 when out of reset.
REQ-015 SHALL keep arbiter state IDLE, OWN0, OWN1 (last/locked owner); IDLE after reset.
REQ-016 SHALL grant, with both ports requesting and no lock held, the port not equal to the last owner; from IDLE, m0 wins.
REQ-017 SHALL, on accepting a transfer with p_lock high, enter OWN<p> locked; the other port waits until a transfer by p is accepted with p_lock low, or p is idle 16 consecutive cycles (lock timeout counter, 4 bits).
REQ-018 SHALL give a single requester a grant in the same cycle (zero-wait) when no lock is held by the other port.
REQ-019 SHALL assert p_readdatavalid exactly 1 cycle after an accepted read by p, tracked in a registered owner tag; p_readdata = ram_readdata when valid, else 0.
REQ-020 SHALL allow back-to-back reads from alternating ports, each returning valid data on consecutive cycles without bubbles.
REQ-021 SHALL treat p_read and p_write high together as a write and ignore the read.
REQ-022 SHALL hold p_waitrequest high whenever p requests but is not granted.

Reset
REQ-023 SHALL, while reset_n low and until the first clk edge after release, drive all waitrequest = 1, readdatavalid = 0, readdata = 0, ram_chipselect = 0, ram_write = 0, ram_clken = 0.
REQ-024 SHALL discard a read in flight when reset asserts; no readdatavalid after release for it.
REQ-025 SHALL clear lock, timeout counter and state to IDLE on reset.

Configuration
REQ-026 SHALL, when OCRAM_ARB_FIXED_PRIO_EN is defined, replace round-robin with fixed priority (m0 always wins when no lock held); lock behaviour unchanged.
REQ-027 SHALL, without OCRAM_ARB_FIXED_PRIO_EN, use the round-robin of REQ-016.

Structure
REQ-028 SHALL place ADDR_W/DATA_W defaults, the state enum (IDLE/OWN0/OWN1) and LOCK_TIMEOUT=16 in package ocram_arb_pkg.
REQ-029 SHALL implement the grant/lock FSM in one sub-module ocram_arb_core; datapath muxing stays in the top.

Verification
REQ-030 SHALL cover: m0 write addr 0x005 data 0xDEADBEEF be 0xF, then m1 read 0x005 -> m1_readdatavalid 1 cycle later with 0xDEADBEEF.
REQ-031 SHALL cover: both ports read every cycle for 8 cycles -> grants alternate m0,m1,...; each port gets 4 readdatavalids, no overlap.
REQ-032 SHALL cover: m1 write with lock high 3 times while m0 requests -> m0_waitrequest high for all 3; m0 granted the cycle after m1 drops lock.
REQ-033 SHALL cover: m0 takes lock then goes idle -> m1 granted after exactly 16 idle cycles.
REQ-034 SHALL cover: reset_n pulsed low the cycle after an accepted m0 read -> no m0_readdatavalid; all outputs at reset values.
REQ-035 SHALL cover: with OCRAM_ARB_FIXED_PRIO_EN, continuous requests from both ports for 6 cycles -> m0 granted all 6, m1 none.

Source files
------------

// File: rtl/ocram_port_arbiter_pkg.sv
// Shared constants and types for the two-port on-chip RAM arbiter.
package ocram_arb_pkg;

  localparam int unsigned ADDR_W_DEF   = 10;
  localparam int unsigned DATA_W_DEF   = 32;

  // A lock owner that stays idle this many consecutive cycles loses its lock.
  localparam int unsigned LOCK_TIMEOUT = 16;
  localparam int unsigned TMO_W        = $clog2(LOCK_TIMEOUT);

  // Arbiter state: no owner since reset, or the last/locked owner.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/ocram_port_arbiter_if.sv
// Avalon-MM style request/response bundle for one arbiter port.
interface ocram_port_arbiter_if import ocram_arb_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                lock;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/ocram_port_arbiter_core.sv
// Grant/lock FSM for the two-port RAM arbiter.
// Build option: define OCRAM_ARB_FIXED_PRIO_EN for fixed priority (m0 wins
// contention); otherwise contention alternates away from the last owner.
module ocram_arb_core import ocram_arb_pkg::*; (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  output logic gnt0,
  output logic gnt1,
  output logic active
);

  arb_state_e       state;
  logic             locked;
  logic [TMO_W-1:0] idle_cnt;
  logic             prefer1;

`ifdef OCRAM_ARB_FIXED_PRIO_EN
  assign prefer1 = 1'b0;
`else
  assign prefer1 = (state == OWN0);
`endif

  // Goes high on the first clock edge after reset release; gates all grants.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) active <= 1'b0;
    else          active <= 1'b1;
  end

  // Combinational grant: lock holder first, then priority on contention.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (active) begin
      if (locked && state == OWN0) begin
        gnt0 = req0;
      end else if (locked && state == OWN1) begin
        gnt1 = req1;
      end else if (req0 && req1) begin
        gnt0 = !prefer1;
        gnt1 = prefer1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Owner/lock tracking with idle timeout on the lock holder.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      locked   <= 1'b0;
      idle_cnt <= '0;
    end else if (gnt0) begin
      state    <= OWN0;
      locked   <= lock0;
      idle_cnt <= '0;
    end else if (gnt1) begin
      state    <= OWN1;
      locked   <= lock1;
      idle_cnt <= '0;
    end else if (locked) begin
      // No grant while locked means the holder was idle this cycle.
      if (idle_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
        locked   <= 1'b0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: rtl/ocram_port_arbiter.sv
// Two-port arbiter in front of a single-port on-chip RAM with 1-cycle read
// latency. Build option OCRAM_ARB_FIXED_PRIO_EN selects fixed priority.
module ocram_port_arbiter import ocram_arb_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  ocram_port_arbiter_if.slave m0,
  ocram_port_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  logic req0, req1;
  logic gnt0, gnt1;
  logic active;
  logic rv0, rv1;

  // Read+write together counts as a write.
  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  ocram_arb_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .lock0   (m0.lock),
    .lock1   (m1.lock),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .active  (active)
  );

  assign m0.waitrequest = ~gnt0;
  assign m1.waitrequest = ~gnt1;

  // RAM-side mux driven from the granted port.
  always_comb begin
    ram_address    = m0.address;
    ram_byteenable = m0.byteenable;
    ram_writedata  = m0.writedata;
    if (gnt1) begin
      ram_address    = m1.address;
      ram_byteenable = m1.byteenable;
      ram_writedata  = m1.writedata;
    end
    ram_chipselect = gnt0 | gnt1;
    ram_write      = (gnt0 & m0.write) | (gnt1 & m1.write);
    ram_clken      = active;
  end

  // Owner tag for the read returning next cycle; reset discards it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv0 <= 1'b0;
      rv1 <= 1'b0;
    end else begin
      rv0 <= gnt0 & ~m0.write;
      rv1 <= gnt1 & ~m1.write;
    end
  end

  assign m0.readdatavalid = rv0;
  assign m1.readdatavalid = rv1;
  assign m0.readdata      = rv0 ? ram_readdata : '0;
  assign m1.readdata      = rv1 ? ram_readdata : '0;

endmodule
